// File: rtl/rv32_pkg.sv
// Shared RV32 definitions: ALUControl codes for the M extension and the
// multiply/divide engine state encoding, plus small op-classification helpers.
package rv32_pkg;

  localparam int XLEN = 32;

  localparam logic [4:0] ALU_MUL    = 5'd10;
  localparam logic [4:0] ALU_MULH   = 5'd11;
  localparam logic [4:0] ALU_MULHSU = 5'd12;
  localparam logic [4:0] ALU_MULHU  = 5'd13;
  localparam logic [4:0] ALU_DIV    = 5'd14;
  localparam logic [4:0] ALU_DIVU   = 5'd15;
  localparam logic [4:0] ALU_REM    = 5'd16;
  localparam logic [4:0] ALU_REMU   = 5'd17;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIN  = 2'd2
  } md_state_e;

  function automatic logic md_is_op(input logic [4:0] code);
    return (code >= ALU_MUL) && (code <= ALU_REMU);
  endfunction

  function automatic logic md_is_mul(input logic [4:0] code);
    return (code >= ALU_MUL) && (code <= ALU_MULHU);
  endfunction

  function automatic logic md_is_rem(input logic [4:0] code);
    return (code == ALU_REM) || (code == ALU_REMU);
  endfunction

  function automatic logic md_a_signed(input logic [4:0] code);
    return (code == ALU_MUL) || (code == ALU_MULH) || (code == ALU_MULHSU) ||
           (code == ALU_DIV) || (code == ALU_REM);
  endfunction

  function automatic logic md_b_signed(input logic [4:0] code);
    return (code == ALU_MUL) || (code == ALU_MULH) ||
           (code == ALU_DIV) || (code == ALU_REM);
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// Request/response bundle between the EX stage and the multiply/divide engine.
interface md_unit_if #(parameter int XLEN = rv32_pkg::XLEN);
  logic            start;
  logic [4:0]      alu_control;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            flush;
  logic            ready;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, alu_control, src_a, src_b, flush,
    input  ready, busy, done, result
  );

  modport slave (
    input  start, alu_control, src_a, src_b, flush,
    output ready, busy, done, result
  );
endinterface

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negate; used both to take operand magnitudes
// and to restore the sign of the final product/quotient/remainder.
module md_sign_fix #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] val_i,
  input  logic              neg_i,
  output logic [DATA_W-1:0] val_o
);
  assign val_o = neg_i ? ('0 - val_i) : val_i;
endmodule

// File: rtl/md_unit.sv
// Sequential RV32M engine: shift-add multiply and restoring divide, one bit
// per cycle, with single-cycle shortcuts for divide-by-zero and overflow.
module md_unit
  import rv32_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  md_unit_if.slave     io
);
  localparam int CNT_W = $clog2(XLEN);

  md_state_e         state_q, state_d;
  logic [4:0]        op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              accept;
  logic              sign_a, sign_b;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic              div_zero, div_ovf;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   div_fix;
  logic [XLEN-1:0]   fin_val;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;

  assign accept = (state_q == MD_IDLE) && io.start && !io.flush && md_is_op(io.alu_control);
  assign sign_a = md_a_signed(io.alu_control) && io.src_a[XLEN-1];
  assign sign_b = md_b_signed(io.alu_control) && io.src_b[XLEN-1];

  assign div_zero = !md_is_mul(io.alu_control) && (io.src_b == '0);
  assign div_ovf  = ((io.alu_control == ALU_DIV) || (io.alu_control == ALU_REM)) &&
                    (io.src_a == {1'b1, {(XLEN-1){1'b0}}}) && (io.src_b == '1);

  md_sign_fix #(.DATA_W(XLEN)) u_abs_a (.val_i(io.src_a), .neg_i(sign_a), .val_o(abs_a));
  md_sign_fix #(.DATA_W(XLEN)) u_abs_b (.val_i(io.src_b), .neg_i(sign_b), .val_o(abs_b));

  md_sign_fix #(.DATA_W(2*XLEN)) u_fix_prod (
    .val_i({hi_q, lo_q}), .neg_i(neg_q), .val_o(prod_fix)
  );
  md_sign_fix #(.DATA_W(XLEN)) u_fix_div (
    .val_i(md_is_rem(op_q) ? hi_q : lo_q), .neg_i(neg_q), .val_o(div_fix)
  );

  // hi:lo is the running product (multiply) or remainder:quotient (divide)
  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = {hi_q, lo_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};

  always_comb begin
    fin_val = div_fix;
    if (op_q == ALU_MUL)     fin_val = prod_fix[XLEN-1:0];
    else if (md_is_mul(op_q)) fin_val = prod_fix[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    neg_d    = neg_q;
    result_d = result_q;
    case (state_q)
      MD_IDLE: begin
        if (accept) begin
          op_d    = io.alu_control;
          cnt_d   = '0;
          hi_d    = '0;
          state_d = MD_RUN;
          if (md_is_mul(io.alu_control)) begin
            lo_d   = abs_b;
            opnd_d = abs_a;
            neg_d  = sign_a ^ sign_b;
          end else begin
            lo_d   = abs_a;
            opnd_d = abs_b;
            neg_d  = md_is_rem(io.alu_control) ? sign_a : (sign_a ^ sign_b);
          end
          // Shortcuts preload quotient/remainder so FIN emits them unchanged
          if (div_zero) begin
            state_d = MD_FIN;
            lo_d    = '1;
            hi_d    = io.src_a;
            neg_d   = 1'b0;
          end else if (div_ovf) begin
            state_d = MD_FIN;
            lo_d    = {1'b1, {(XLEN-1){1'b0}}};
            hi_d    = '0;
            neg_d   = 1'b0;
          end
        end
      end
      MD_RUN: begin
        if (io.flush) begin
          state_d = MD_IDLE;
        end else begin
          if (md_is_mul(op_q)) begin
            hi_d = mul_sum[XLEN:1];
            lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
          end else if (!div_diff[XLEN]) begin
            hi_d = div_diff[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b1};
          end else begin
            hi_d = div_shift[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b0};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(XLEN-1)) begin
            cnt_d   = '0;
            state_d = MD_FIN;
          end
        end
      end
      MD_FIN: begin
        state_d = MD_IDLE;
        if (!io.flush) result_d = fin_val;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= MD_IDLE;
      op_q     <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  // FIN presents the fresh value directly so it is usable alongside done
  assign io.ready  = (state_q == MD_IDLE);
  assign io.busy   = (state_q == MD_RUN) || accept;
  assign io.done   = (state_q == MD_FIN) && !io.flush;
  assign io.result = io.done ? fin_val : result_q;

endmodule
